// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file constants
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with rotating pointer
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         any_grant
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] next_ptr;
    logic          found;
    int            idx;

    // first requesting index at or after rr_ptr, wrapping; pointer moves past the winner
    always_comb begin
        grant    = '0;
        next_ptr = rr_ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    assign any_grant = found;

    // pointer only advances when something was granted
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= next_ptr;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back port arbiter with per-requester holding buffers
module regfile_wb_arbiter
    import mips_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic [2:0]                grant_id,
    output logic [2**ADDR_W-1:0]      pend_mask
);
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] grant;
    logic               any_grant;
    logic [ADDR_W-1:0]  buf_addr [NUM_REQ];
    logic [DATA_W-1:0]  buf_data [NUM_REQ];
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;
    logic [2:0]         win_id;

    // a buffer leaving for the output stage this cycle can take a new entry at the same edge
    assign req_ready = ~full | grant;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (full),
        .grant     (grant),
        .any_grant (any_grant)
    );

    // holding buffers: load on accept (r0 writes are swallowed), empty on grant
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                full[i] <= 1'b0;
            end else if (req_valid[i] && req_ready[i] &&
                         req_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO)) begin
                full[i]     <= 1'b1;
                buf_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
                buf_data[i] <= req_data[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
                full[i] <= 1'b0;
            end
        end
    end

    // select the granted buffer's contents
    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_addr = buf_addr[i];
                win_data = buf_data[i];
                win_id   = 3'(i);
            end
        end
    end

    // registered write port; address/data/id hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            grant_id   <= '0;
        end else if (any_grant) begin
            RegWrite   <= 1'b1;
            write_addr <= win_addr;
            write_data <= win_data;
            grant_id   <= win_id;
        end else begin
            RegWrite   <= 1'b0;
        end
    end

    // registers with a write still buffered or on the output stage
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (full[i]) pend_mask[buf_addr[i]] = 1'b1;
        end
        if (RegWrite) pend_mask[write_addr] = 1'b1;
        pend_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR*AW-1:0]   req_addr = '0;
    logic [NR*DW-1:0]   req_data = '0;
    logic               RegWrite;
    logic [AW-1:0]      write_addr;
    logic [DW-1:0]      write_data;
    logic [2:0]         grant_id;
    logic [2**AW-1:0]   pend_mask;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          log_id   [$];
    int          log_addr [$];
    logic [31:0] log_data [$];
    int          log_cyc  [$];

    int          exp_addr0 [$];
    logic [31:0] exp_data0 [$];
    int          exp_addr1 [$];
    logic [31:0] exp_data1 [$];

    regfile_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .RegWrite   (RegWrite),
        .write_addr (write_addr),
        .write_data (write_data),
        .grant_id   (grant_id),
        .pend_mask  (pend_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            log_id.push_back(int'(grant_id));
            log_addr.push_back(int'(write_addr));
            log_data.push_back(write_data);
            log_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_id.delete();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic set_req(input int i, input int a, input logic [31:0] d);
        req_addr[i*AW +: AW] = AW'(a);
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        int a0;
        int a1;
        logic [NR-1:0] exp_rdy;

        // reset state
        do_reset();
        check("rst_regwrite", RegWrite, 0);
        check("rst_waddr", write_addr, 0);
        check("rst_wdata", write_data, 0);
        check("rst_gid", grant_id, 0);
        check("rst_ready", req_ready, 3'b111);
        check("rst_pend", pend_mask, 0);

        // single write
        set_req(0, 5, 32'hDEADBEEF);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        check("sw_regwrite_n1", RegWrite, 0);
        check("sw_pend_n1", pend_mask[5], 1);
        tick();
        check("sw_regwrite_n2", RegWrite, 1);
        check("sw_waddr", write_addr, 5);
        check("sw_wdata", write_data, 32'hDEADBEEF);
        check("sw_gid", grant_id, 0);
        check("sw_pend_n2", pend_mask[5], 1);
        tick();
        check("sw_regwrite_n3", RegWrite, 0);
        check("sw_pend_n3", pend_mask, 0);

        // full contention, then a second round led by requester 1
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, i + 1, 32'h100 + i);
        req_valid = 3'b111;
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("ct_count1", log_id.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("ct_id_r1", log_id[i], i);
            check("ct_addr_r1", log_addr[i], i + 1);
            check("ct_data_r1", log_data[i], 32'h100 + i);
        end
        check("ct_consec_a", log_cyc[1] - log_cyc[0], 1);
        check("ct_consec_b", log_cyc[2] - log_cyc[1], 1);
        set_req(1, 4, 32'h201);
        req_valid = 3'b010;
        tick();
        set_req(0, 6, 32'h200);
        set_req(2, 5, 32'h202);
        req_valid = 3'b101;
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("ct_count2", log_id.size(), 6);
        check("ct_id_r2a", log_id[3], 1);
        check("ct_id_r2b", log_id[4], 2);
        check("ct_id_r2c", log_id[5], 0);
        check("ct_addr_r2c", log_addr[5], 6);

        // address 0 is swallowed
        do_reset();
        set_req(2, 0, 32'h1234);
        req_valid = 3'b100;
        check("z_ready_acc", req_ready[2], 1);
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            check("z_ready", req_ready[2], 1);
            check("z_regwrite", RegWrite, 0);
            check("z_pend", pend_mask, 0);
            tick();
        end
        check("z_nowrite", log_id.size(), 0);

        // streaming from one requester
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_req(1, 8 + k, 32'hC000 + k);
            req_valid = 3'b010;
            check("st_ready", req_ready[1], 1);
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
        check("st_count", log_id.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check("st_addr", log_addr[k], 8 + k);
            check("st_data", log_data[k], 32'hC000 + k);
            if (k > 0) check("st_consec", log_cyc[k] - log_cyc[k-1], 1);
        end

        // back-pressure between two continuous requesters
        do_reset();
        a0 = 0;
        a1 = 0;
        for (int k = 0; k < 20; k++) begin
            req_valid = {1'b0, (a1 < 8), (a0 < 8)};
            set_req(0, 16 + a0, 32'hA000 + a0);
            set_req(1, 24 + a1, 32'hB000 + a1);
            if (a0 < 8 && a1 < 8) begin
                exp_rdy = (k == 0) ? 3'b111 : ((k % 2 == 1) ? 3'b101 : 3'b110);
                check("bp_ready", req_ready, exp_rdy);
            end
            if (req_valid[0] && req_ready[0]) begin
                exp_addr0.push_back(16 + a0);
                exp_data0.push_back(32'hA000 + a0);
                a0++;
            end
            if (req_valid[1] && req_ready[1]) begin
                exp_addr1.push_back(24 + a1);
                exp_data1.push_back(32'hB000 + a1);
                a1++;
            end
            tick();
        end
        req_valid = '0;
        repeat (4) tick();
        check("bp_count", log_id.size(), 16);
        for (int k = 0; k < log_id.size(); k++) begin
            if (log_id[k] == 0 && exp_addr0.size() > 0) begin
                check("bp_addr0", log_addr[k], exp_addr0.pop_front());
                check("bp_data0", log_data[k], exp_data0.pop_front());
            end else if (log_id[k] == 1 && exp_addr1.size() > 0) begin
                check("bp_addr1", log_addr[k], exp_addr1.pop_front());
                check("bp_data1", log_data[k], exp_data1.pop_front());
            end else begin
                check("bp_unexpected_id", log_id[k], 99);
            end
        end
        check("bp_left0", exp_addr0.size(), 0);
        check("bp_left1", exp_addr1.size(), 0);

        // reset with two buffers full
        do_reset();
        set_req(0, 7, 32'h777);
        set_req(1, 9, 32'h999);
        req_valid = 3'b011;
        tick();
        req_valid = '0;
        check("mr_pend_before", pend_mask, (64'd1 << 7) | (64'd1 << 9));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_regwrite", RegWrite, 0);
        check("mr_pend", pend_mask, 0);
        check("mr_ready", req_ready, 3'b111);
        repeat (5) tick();
        check("mr_lost", log_id.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
